// File: rtl/proc_pkg.sv
// Shared definitions for the accumulator processor and its program loader.
package proc_pkg;

    localparam int unsigned PROC_ADDR_WIDTH   = 6;
    localparam int unsigned PROC_DATA_WIDTH   = 11;
    localparam int unsigned PROC_OPCODE_WIDTH = 5;

    // Processor port-select codes; the even (IN) codes steer a port into its memory.
    localparam logic [3:0] PA_IN  = 4'b0000;
    localparam logic [3:0] PA_OUT = 4'b0001;
    localparam logic [3:0] PB_IN  = 4'b0010;
    localparam logic [3:0] PB_OUT = 4'b0011;
    localparam logic [3:0] PC_IN  = 4'b0100;
    localparam logic [3:0] PC_OUT = 4'b0101;
    localparam logic [3:0] PD_IN  = 4'b0110;
    localparam logic [3:0] PD_OUT = 4'b0111;

    // Processor opcodes (upper field of each program word).
    localparam logic [4:0] OP_NOP = 5'd0;
    localparam logic [4:0] OP_LDA = 5'd1;
    localparam logic [4:0] OP_ADD = 5'd2;
    localparam logic [4:0] OP_SUB = 5'd3;
    localparam logic [4:0] OP_STA = 5'd4;
    localparam logic [4:0] OP_JMP = 5'd5;
    localparam logic [4:0] OP_JZ  = 5'd6;
    localparam logic [4:0] OP_HLT = 5'd31;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrive,
        StRelease
    } loader_state_e;

    // Map a target bank number onto the processor's write port-select code.
    function automatic logic [3:0] bank_to_sel(input logic [1:0] bank);
        logic [3:0] sel;
        unique case (bank)
            2'd0:    sel = PA_IN;
            2'd1:    sel = PB_IN;
            2'd2:    sel = PC_IN;
            default: sel = PD_IN;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count; push while full is honoured if a pop
// happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  rd_ptr;
    logic [PtrW-1:0]  wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PtrW + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage array; contents are only observed through count-qualified reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Bus master that streams buffered words into one of the processor's memories, holding
// each address/data pair long enough to cover the processor's port-capture latency.
module prog_loader
    import proc_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = PROC_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = PROC_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic [1:0]            bank,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  wr,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [3:0]            port_sel,
    output logic [DATA_WIDTH-1:0] port_data,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned HoldW = $clog2(HOLD_CYCLES);
    localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_CYCLES - 1);

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic [CntW-1:0]       fifo_count;

    loader_state_e         state;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH:0]   remaining;
    logic [1:0]            bank_lat;
    logic [HoldW-1:0]      hold;
    logic                  after_session;

    // A pop in FETCH frees a slot, so a full FIFO can still accept that cycle.
    assign fifo_pop  = (state == StFetch) && !fifo_empty;
    assign in_ready  = !fifo_full || fifo_pop;
    assign fifo_push = in_valid && in_ready;

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (in_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Session FSM with registered bus outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= StIdle;
            cur_addr      <= '0;
            remaining     <= '0;
            bank_lat      <= '0;
            hold          <= '0;
            after_session <= 1'b0;
            wr            <= 1'b0;
            address       <= '0;
            port_sel      <= '0;
            port_data     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        cur_addr      <= base_addr;
                        remaining     <= length;
                        bank_lat      <= bank;
                        overflow      <= 1'b0;
                        after_session <= 1'b0;
                        if (length == '0) begin
                            done <= 1'b1;
                        end else begin
                            busy  <= 1'b1;
                            state <= StFetch;
                        end
                    end else if (after_session && fifo_count != '0) begin
                        overflow <= 1'b1;
                    end
                end
                StFetch: begin
                    // While starved, wr stays up and the previous pair is simply rewritten.
                    if (!fifo_empty) begin
                        port_data <= fifo_dout;
                        address   <= cur_addr;
                        port_sel  <= bank_to_sel(bank_lat);
                        wr        <= 1'b1;
                        hold      <= HoldLoad;
                        state     <= StDrive;
                    end
                end
                StDrive: begin
                    if (hold != '0) begin
                        hold <= hold - 1'b1;
                    end else begin
                        remaining <= remaining - 1'b1;
                        cur_addr  <= cur_addr + 1'b1;
                        state     <= (remaining == (ADDR_WIDTH + 1)'(1)) ? StRelease : StFetch;
                    end
                end
                StRelease: begin
                    wr            <= 1'b0;
                    busy          <= 1'b0;
                    done          <= 1'b1;
                    after_session <= 1'b1;
                    if (fifo_count != '0) begin
                        overflow <= 1'b1;
                    end
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Randomised self-checking bench for prog_loader with a behavioural processor memory model.
module tb_prog_loader;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 11;
    localparam int unsigned FD = 4;
    localparam int unsigned HC = 2;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          start     = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length    = '0;
    logic [1:0]    bank      = '0;
    logic          in_valid  = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          in_ready;
    logic          wr;
    logic [AW-1:0] address;
    logic [3:0]    port_sel;
    logic [DW-1:0] port_data;
    logic          busy;
    logic          done;
    logic          overflow;

    always #5 clk = ~clk;

    prog_loader #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (FD),
        .HOLD_CYCLES (HC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .bank      (bank),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr        (wr),
        .address   (address),
        .port_sel  (port_sel),
        .port_data (port_data),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    int n_vec = 0;
    int n_err = 0;

    // Processor model: port data is registered one edge before it reaches memory.
    logic [DW-1:0] mem [4][64];
    logic [DW-1:0] port_q = '0;

    logic [DW-1:0] model_q[$];   // words accepted by the loader, in order
    logic [DW-1:0] feed_q[$];    // words still to be offered upstream
    logic [AW-1:0] wr_log[$];    // address seen on every cycle with wr high
    int   feed_gap  = 0;
    int   gap_cnt   = 0;
    int   done_cnt  = 0;
    int   wr_rises  = 0;
    int   sel_bad   = 0;
    bit   took      = 1'b0;
    bit   prev_wr   = 1'b0;
    logic [3:0] exp_sel = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] sel_code(input logic [1:0] b);
        case (b)
            2'd0:    return 4'b0000;
            2'd1:    return 4'b0010;
            2'd2:    return 4'b0100;
            default: return 4'b0110;
        endcase
    endfunction

    // One clock: observe at the falling edge, then update stimulus just after the rising edge.
    task automatic tick();
        logic [DW-1:0] tmp;
        @(negedge clk);
        took = in_valid && in_ready;
        if (took) model_q.push_back(in_data);
        if (wr) begin
            wr_log.push_back(address);
            if (port_sel !== exp_sel) sel_bad++;
            mem[port_sel[2:1]][address] = port_q;
        end
        port_q = port_data;
        if (wr && !prev_wr) wr_rises++;
        prev_wr = wr;
        if (done) done_cnt++;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (took) begin
            tmp      = feed_q.pop_front();
            in_valid = 1'b0;
            gap_cnt  = feed_gap;
        end
        if (!in_valid && feed_q.size() != 0) begin
            if (gap_cnt == 0) begin
                in_valid = 1'b1;
                in_data  = feed_q[0];
            end else begin
                gap_cnt--;
            end
        end
    endtask

    task automatic wait_accepted(input int target);
        int guard = 0;
        while (model_q.size() < target && guard < 200) begin
            tick();
            guard++;
        end
        check_eq("preload_count", 32'(model_q.size()), 32'(target));
    endtask

    task automatic begin_session(input int base, input int len, input logic [1:0] bk);
        base_addr = AW'(base);
        length    = (AW + 1)'(len);
        bank      = bk;
        exp_sel   = sel_code(bk);
        wr_log.delete();
        done_cnt  = 0;
        wr_rises  = 0;
        sel_bad   = 0;
        start     = 1'b1;
        tick();
    endtask

    task automatic finish_session(input string tag, input int base, input int len,
                                  input logic [1:0] bk);
        int            guard = 0;
        int            bad   = 0;
        logic [AW-1:0] runs[$];
        logic [AW-1:0] a;
        logic [DW-1:0] w;
        while (done_cnt == 0 && guard < 2000) begin
            tick();
            guard++;
        end
        check_eq({tag, " done_seen"}, 32'(done_cnt != 0), 32'd1);
        check_eq({tag, " wr_low_after"}, 32'(wr), 32'd0);
        check_eq({tag, " busy_low_after"}, 32'(busy), 32'd0);
        repeat (3) tick();
        check_eq({tag, " done_once"}, 32'(done_cnt), 32'd1);
        check_eq({tag, " wr_contiguous"}, 32'(wr_rises), 32'd1);
        check_eq({tag, " port_sel"}, 32'(sel_bad), 32'd0);
        foreach (wr_log[i]) begin
            if (runs.size() == 0 || runs[runs.size() - 1] != wr_log[i]) runs.push_back(wr_log[i]);
        end
        check_eq({tag, " addr_count"}, 32'(runs.size()), 32'(len));
        foreach (runs[i]) begin
            if (runs[i] != AW'(base + i)) bad++;
        end
        check_eq({tag, " addr_order"}, 32'(bad), 32'd0);
        for (int i = 0; i < len && model_q.size() != 0; i++) begin
            w = model_q.pop_front();
            a = AW'(base + i);
            check_eq({tag, " mem_word"}, 32'(mem[bk][a]), 32'(w));
        end
        check_eq({tag, " overflow"}, 32'(overflow), 32'(model_q.size() != 0));
    endtask

    initial begin
        int bad;
        int base;
        int len;
        logic [1:0] bk;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst wr", 32'(wr), 32'd0);
        check_eq("rst address", 32'(address), 32'd0);
        check_eq("rst port_sel", 32'(port_sel), 32'd0);
        check_eq("rst port_data", 32'(port_data), 32'd0);
        check_eq("rst busy", 32'(busy), 32'd0);
        check_eq("rst done", 32'(done), 32'd0);
        check_eq("rst overflow", 32'(overflow), 32'd0);
        check_eq("rst in_ready", 32'(in_ready), 32'd1);
        reset = 1'b1;
        tick();

        // Preloaded three-word program into bank A at address 0.
        feed_gap = 0;
        feed_q.push_back({5'b00010, 6'd34});
        feed_q.push_back({5'b00101, 6'd35});
        feed_q.push_back({5'b00001, 6'd36});
        wait_accepted(3);
        begin_session(0, 3, 2'd0);
        finish_session("preload", 0, 3, 2'd0);
        check_eq("preload wr_cycles", 32'(wr_log.size()), 32'd9);
        bad = 0;
        foreach (wr_log[i]) if (wr_log[i] != AW'(i / 3)) bad++;
        check_eq("preload addr_trace", 32'(bad), 32'd0);

        // Zero-length session.
        begin_session(7, 0, 2'd1);
        check_eq("len0 done_pulse", 32'(done), 32'd1);
        check_eq("len0 busy", 32'(busy), 32'd0);
        tick();
        check_eq("len0 done_clears", 32'(done), 32'd0);
        repeat (3) tick();
        check_eq("len0 no_writes", 32'(wr_log.size()), 32'd0);
        check_eq("len0 busy_stays", 32'(busy), 32'd0);

        // Slow stream across the address wrap into bank C.
        feed_gap = 4;
        for (int i = 1; i <= 4; i++) feed_q.push_back(DW'(11'h100 + i));
        begin_session(62, 4, 2'd2);
        finish_session("wrap", 62, 4, 2'd2);
        check_eq("wrap memC62", 32'(mem[2][62]), 32'h101);
        check_eq("wrap memC1", 32'(mem[2][1]), 32'h104);

        // Start while busy is ignored.
        feed_gap = 0;
        for (int i = 0; i < 3; i++) feed_q.push_back(DW'($urandom));
        wait_accepted(3);
        begin_session(10, 3, 2'd1);
        repeat (3) tick();
        base_addr = 6'd20;
        start     = 1'b1;
        tick();
        base_addr = 6'd10;
        finish_session("busy_start", 10, 3, 2'd1);

        // Overflow: six words offered back-to-back, two consumed.
        for (int i = 0; i < 6; i++) feed_q.push_back(DW'($urandom));
        repeat (8) tick();
        check_eq("ovf in_ready_full", 32'(in_ready), 32'd0);
        check_eq("ovf buffered", 32'(model_q.size()), 32'(FD));
        begin_session(40, 2, 2'd3);
        finish_session("ovf_session", 40, 2, 2'd3);
        check_eq("ovf sticky", 32'(overflow), 32'd1);
        begin_session(50, 4, 2'd1);
        check_eq("ovf cleared_by_start", 32'(overflow), 32'd0);
        finish_session("ovf_drain", 50, 4, 2'd1);

        // Randomised sessions with words streamed during the session.
        for (int s = 0; s < 6; s++) begin
            base     = int'($urandom_range(0, 63));
            len      = int'($urandom_range(1, 8));
            bk       = 2'($urandom_range(0, 3));
            feed_gap = int'($urandom_range(0, 5));
            for (int i = 0; i < len; i++) feed_q.push_back(DW'($urandom));
            begin_session(base, len, bk);
            finish_session("random", base, len, bk);
        end

        // Asynchronous reset in the middle of the second word of four.
        feed_gap = 0;
        for (int i = 0; i < 4; i++) feed_q.push_back(DW'($urandom));
        wait_accepted(4);
        begin_session(0, 4, 2'd0);
        bad = 0;
        while (wr_log.size() < 4 && bad < 100) begin
            tick();
            bad++;
        end
        check_eq("rst_mid reached_word2", 32'(wr_log.size() >= 4), 32'd1);
        reset = 1'b0;
        #1;
        check_eq("rst_mid wr", 32'(wr), 32'd0);
        check_eq("rst_mid busy", 32'(busy), 32'd0);
        check_eq("rst_mid in_ready", 32'(in_ready), 32'd1);
        model_q.delete();
        feed_q.delete();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        repeat (5) tick();
        check_eq("rst_mid no_done", 32'(done_cnt), 32'd0);
        begin_session(5, 1, 2'd0);
        repeat (10) tick();
        check_eq("rst_mid fifo_empty", 32'(wr_log.size()), 32'd0);
        feed_q.push_back(DW'($urandom));
        finish_session("post_reset", 5, 1, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
